// File: rtl/core_pkg.sv
// Shared core definitions used by the fetch front end.
package core_pkg;
    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with clear; registered head, simultaneous push/pop at any occupancy.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        // A push into a full queue is only legal when the head leaves in the same cycle.
        do_push  = push && ((count_q != FULL_CNT) || pop);
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clear && do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch queue: credit-limited sequential fetch, in-order response
// tagging, and redirect handling that discards responses from the abandoned path.
module fetch_prefetch_buffer #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = core_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o
);
    import core_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         discard_q, discard_d;
    logic [CW-1:0]         fifo_count, tag_count_unused;
    logic [CW:0]           credit_used;
    logic                  fifo_empty, fifo_full_unused;
    logic                  tag_full, tag_empty;
    logic                  grant, accept, pop_instr;
    logic [DATA_WIDTH-1:0] tag_pc;
    logic [1:0]            redirect_pc_unused;
    fetch_entry_t          push_entry, head_entry;

    assign redirect_pc_unused = redirect_pc_i[1:0];

    always_comb begin
        credit_used   = {1'b0, fifo_count} + {1'b0, outstanding_q};
        imem_req_o    = !rst && !redirect_i && !tag_full && (credit_used < (CW+1)'(DEPTH));
        imem_addr_o   = fetch_pc_q;
        grant         = imem_req_o && imem_gnt_i;
        accept        = imem_rvalid_i && (discard_q == '0) && !redirect_i && !tag_empty;
        instr_valid_o = !rst && !fifo_empty;
        pop_instr     = instr_valid_o && instr_ready_i && !redirect_i;
        instr_o       = instr_valid_o ? head_entry.instr : '0;
        pc_o          = instr_valid_o ? head_entry.pc : '0;
        push_entry.pc    = tag_pc;
        push_entry.instr = imem_rdata_i;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid_i);
        discard_d     = discard_q;
        if (grant) fetch_pc_d = fetch_pc_q + DATA_WIDTH'(PC_STEP);
        // Every response still in flight after this cycle belongs to the old path.
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            discard_d  = outstanding_q - CW'(imem_rvalid_i);
        end else if (imem_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop_instr),
        .clear (redirect_i),
        .din   (push_entry),
        .dout  (head_entry),
        .full  (fifo_full_unused),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .pop   (accept),
        .clear (redirect_i),
        .din   (fetch_pc_q),
        .dout  (tag_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count_unused)
    );
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Self-checking bench: bus-level memory model plus a queue-based model of the
// expected instruction stream, driven with randomized grant/ready/redirect traffic.
module tb_fetch_prefetch_buffer;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] MAGIC    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst, imem_req_o, imem_gnt_i, imem_rvalid_i, redirect_i;
    logic        instr_valid_o, instr_ready_i;
    logic [31:0] imem_addr_o, imem_rdata_i, redirect_pc_i, instr_o, pc_o;

    always #5 clk = ~clk;

    fetch_prefetch_buffer #(
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int unsigned due;
        int unsigned epoch;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    mreq_t       memq[$];
    ent_t        mf[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0, epoch = 0, lat = 1, last_due = 0;
    int unsigned grants = 0, pops = 0;
    int          gnt_mode = 0, ready_mode = 0;
    logic [31:0] exp_pc = RESET_PC;

    function automatic logic pick(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return (cyc % 2 == 0);
            default: return 1'b1 & $urandom_range(0, 1);
        endcase
    endfunction

    task automatic tick(input logic redir, input logic [31:0] rpc);
        logic        rv, live, exp_req;
        ent_t        resp;
        int unsigned due;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        imem_gnt_i    = pick(gnt_mode);
        instr_ready_i = pick(ready_mode);
        rv   = 1'b0;
        live = 1'b0;
        resp.pc    = '0;
        resp.instr = '0;
        if (!rst && memq.size() > 0 && memq[0].due <= cyc) begin
            rv         = 1'b1;
            resp.pc    = memq[0].pc;
            resp.instr = memq[0].addr ^ MAGIC;
            live       = (memq[0].epoch == epoch);
            void'(memq.pop_front());
        end
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? resp.instr : $urandom;
        @(negedge clk);
        if (rst) begin
            checks++;
            if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs: got req=%0b valid=%0b instr=%h pc=%h, required all zero",
                         imem_req_o, instr_valid_o, instr_o, pc_o);
            end
            memq.delete();
            mf.delete();
            exp_pc = RESET_PC;
            epoch++;
        end else begin
            exp_req = !redir && ((mf.size() + memq.size() + int'(rv)) < DEPTH);
            checks++;
            if (imem_req_o !== exp_req) begin
                errors++;
                $display("FAIL credit_req: cycle %0d got %0b required %0b", cyc, imem_req_o, exp_req);
            end
            if (imem_req_o === 1'b1) begin
                checks++;
                if (imem_addr_o !== exp_pc) begin
                    errors++;
                    $display("FAIL fetch_addr: cycle %0d got %h required %h", cyc, imem_addr_o, exp_pc);
                end
            end
            checks++;
            if (instr_valid_o !== (mf.size() != 0)) begin
                errors++;
                $display("FAIL instr_valid: cycle %0d got %0b required %0b", cyc, instr_valid_o, mf.size() != 0);
            end
            if (mf.size() != 0 && instr_valid_o === 1'b1) begin
                checks++;
                if (pc_o !== mf[0].pc || instr_o !== mf[0].instr) begin
                    errors++;
                    $display("FAIL head_entry: cycle %0d got pc=%h instr=%h required pc=%h instr=%h",
                             cyc, pc_o, instr_o, mf[0].pc, mf[0].instr);
                end
            end
            if (redir) begin
                mf.delete();
                epoch++;
                exp_pc = rpc & ~32'd3;
            end else begin
                if (instr_valid_o === 1'b1 && instr_ready_i && mf.size() > 0) begin
                    void'(mf.pop_front());
                    pops++;
                end
                if (rv && live) mf.push_back(resp);
                if (imem_req_o === 1'b1 && imem_gnt_i) begin
                    due = (cyc + lat > last_due) ? cyc + lat : last_due;
                    last_due = due;
                    memq.push_back('{addr: imem_addr_o, pc: exp_pc, due: due, epoch: epoch});
                    exp_pc = exp_pc + 32'd4;
                    grants++;
                end
            end
            checks++;
            if (mf.size() > DEPTH) begin
                errors++;
                $display("FAIL fifo_overflow: cycle %0d occupancy %0d exceeds %0d", cyc, mf.size(), DEPTH);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick(1'b0, 32'h0);
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (instr_valid_o !== 1'b1 && n < 30) begin
            tick(1'b0, $urandom);
            n++;
        end
        if (n >= 30) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: instr_valid_o not seen within 30 cycles", name);
        end
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== RESET_PC || instr_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got req=%0b addr=%h valid=%0b required 1 %h 0",
                     imem_req_o, imem_addr_o, instr_valid_o, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int unsigned p0;
        gnt_mode = 0; ready_mode = 0; lat = 1;
        do_reset(1);
        tick(1'b0, 32'h0);
        tick(1'b0, 32'h0);
        checks++;
        if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== MAGIC) begin
            errors++;
            $display("FAIL stream_first: got valid=%0b pc=%h instr=%h required 1 0 %h",
                     instr_valid_o, pc_o, instr_o, MAGIC);
        end
        repeat (2) tick(1'b0, 32'h0);
        p0 = pops;
        repeat (8) tick(1'b0, 32'h0);
        checks++;
        if (pops - p0 != 8) begin
            errors++;
            $display("FAIL stream_throughput: got %0d pops required 8", pops - p0);
        end
    endtask

    task automatic test_backpressure();
        int unsigned g0;
        gnt_mode = 0; ready_mode = 1; lat = 1;
        do_reset(1);
        g0 = grants;
        repeat (10) tick(1'b0, 32'h0);
        checks++;
        if (grants - g0 != DEPTH || instr_valid_o !== 1'b1 || pc_o !== 32'h0 || imem_addr_o !== 32'h10) begin
            errors++;
            $display("FAIL backpressure: got grants=%0d valid=%0b pc=%h addr=%h required %0d 1 0 10",
                     grants - g0, instr_valid_o, pc_o, imem_addr_o, DEPTH);
        end
        ready_mode = 0;
        repeat (12) tick(1'b0, 32'h0);
    endtask

    task automatic test_gnt_toggle();
        gnt_mode = 2; ready_mode = 0; lat = 3;
        do_reset(1);
        repeat (30) tick(1'b0, 32'h0);
    endtask

    task automatic test_redirect();
        int n = 0;
        gnt_mode = 0; ready_mode = 0; lat = 3;
        do_reset(1);
        while (memq.size() < 3 && n < 20) begin
            tick(1'b0, 32'h0);
            n++;
        end
        tick(1'b1, 32'h0000_0102);
        checks++;
        if (imem_addr_o !== 32'h100 || instr_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL redirect_addr: got addr=%h valid=%0b required 100 0", imem_addr_o, instr_valid_o);
        end
        wait_valid("redirect");
        checks++;
        if (pc_o !== 32'h100 || instr_o !== (32'h100 ^ MAGIC)) begin
            errors++;
            $display("FAIL redirect_first: got pc=%h instr=%h required 100 %h", pc_o, instr_o, 32'h100 ^ MAGIC);
        end
    endtask

    task automatic test_redirect_full();
        int n = 0;
        gnt_mode = 0; ready_mode = 1; lat = 2;
        do_reset(1);
        while (!(mf.size() >= 3 && memq.size() > 0 && memq[0].due <= cyc) && n < 20) begin
            tick(1'b0, 32'h0);
            n++;
        end
        ready_mode = 0;
        tick(1'b1, 32'h0000_4000 | ($urandom & 32'hFFF));
        checks++;
        if (instr_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL redirect_full_valid: got %0b required 0", instr_valid_o);
        end
        repeat (20) tick(1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] b;
        gnt_mode = 0; ready_mode = 0; lat = 2;
        repeat (6) tick(1'b0, 32'h0);
        b = $urandom;
        tick(1'b1, 32'h0000_8000);
        tick(1'b1, b);
        wait_valid("back_to_back");
        checks++;
        if (pc_o !== (b & ~32'd3)) begin
            errors++;
            $display("FAIL back_to_back_pc: got %h required %h", pc_o, b & ~32'd3);
        end
    endtask

    task automatic test_reset_mid();
        gnt_mode = 3; ready_mode = 3; lat = 2;
        repeat (10) tick(1'b0, 32'h0);
        do_reset(1);
        checks++;
        if (imem_addr_o !== RESET_PC || imem_req_o !== 1'b1 || instr_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_restart: got addr=%h req=%0b valid=%0b required %h 1 0",
                     imem_addr_o, imem_req_o, instr_valid_o, RESET_PC);
        end
        repeat (10) tick(1'b0, 32'h0);
    endtask

    task automatic test_random();
        gnt_mode = 3; ready_mode = 3;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 4);
            tick(($urandom_range(0, 15) == 0), $urandom);
        end
    endtask

    initial begin
        rst = 1'b1;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = '0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_toggle();
        test_redirect();
        test_redirect_full();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/fetch_prefetch_buffer.md
Name: fetch_prefetch_buffer

Overview:
- Instruction prefetch queue between instruction memory and the IF/ID pipeline register of the 5-stage core.
- Issues sequential word fetches to a pipelined instruction-memory port (request/grant, in-order response) and buffers returned instructions with their PCs in a small FIFO.
- Presents instructions to the decode side over a valid/ready handshake.
- Handles branch/jump redirects from EX: clears the queue and discards responses still in flight for the old path.

Parameters:
- DATA_WIDTH, 32, instruction and address width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- imem_req_o  output  1  fetch request valid.
- imem_addr_o  output  DATA_WIDTH  fetch address, word aligned.
- imem_gnt_i  input  1  request accepted this cycle (handshake completes when req && gnt).
- imem_rvalid_i  input  1  response valid; responses return in order, at least 1 cycle after grant.
- imem_rdata_i  input  DATA_WIDTH  returned instruction.
- redirect_i  input  1  PC redirect from EX (taken branch or jump).
- redirect_pc_i  input  DATA_WIDTH  redirect target; bits [1:0] are ignored and treated as 0.
- instr_valid_o  output  1  FIFO head is valid.
- instr_ready_i  input  1  consumer accepts the head (deasserted by a hazard stall).
- instr_o  output  DATA_WIDTH  head instruction.
- pc_o  output  DATA_WIDTH  PC of the head instruction.

Behaviour:
- Reset:
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0.
  - imem_req_o = 0, instr_valid_o = 0, instr_o = 0, pc_o = 0 during the reset cycle.
- Credit rule:
  - imem_req_o = !rst && !redirect_i && (count + outstanding < DEPTH).
  - The FIFO therefore never overflows. A push to a full FIFO is impossible by construction; the verification environment asserts this.
- Issue:
  - imem_addr_o = fetch_pc.
  - On req && gnt: fetch_pc += 4 (wraps modulo 2^DATA_WIDTH); outstanding increments.
  - The request PC is pushed into an internal PC tag queue of depth DEPTH.
- Response:
  - On imem_rvalid_i: outstanding decrements.
  - If discard > 0: discard decrements and the data is dropped.
  - Otherwise {tag-queue head PC, imem_rdata_i} is pushed into the FIFO.
- Output:
  - Registered FIFO with no bypass. instr_valid_o rises the cycle after the first valid rvalid.
  - A pop occurs on instr_valid_o && instr_ready_i.
  - Push and pop in the same cycle are allowed at any occupancy, including full and empty-with-pending-push.
- Redirect (takes priority over everything in that cycle):
  - fetch_pc <= {redirect_pc_i[DW-1:2], 2'b00}.
  - FIFO and PC tag queue are cleared.
  - discard <= outstanding - (imem_rvalid_i ? 1 : 0) + discard-adjust. All in-flight responses, including any granted in this cycle, are dropped. A response arriving in the redirect cycle is dropped.
  - imem_req_o is forced to 0 in the redirect cycle, so no new grant can occur in that cycle.
  - instr_valid_o is 0 the cycle after the redirect.
  - The first new-path request is issued the cycle after the redirect.
- Back-to-back redirects: the second redirect overrides the first, and discard accounting stays consistent.
- Reset mid-operation: every register returns to its reset value in that cycle. Memory responses arriving after reset for pre-reset requests are the environment's responsibility; the memory is reset with the core.
- Steady-state throughput: 1 instruction per cycle when gnt is held at 1, response latency is 1, and ready is held at 1.

Decomposition:
- core_pkg gains:
  - RESET_PC constant.
  - fetch_entry_t struct {pc, instr}.
  - PC_STEP = 4.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports clk, rst, push, pop, clear, din, dout, full, empty, count).
  - Instantiated twice: as the instruction FIFO over fetch_entry_t, and as the PC tag queue.
- Outstanding/discard counters and the credit logic live in the top module.

Test Plan:
1. Reset release, gnt = 1, 1-cycle latency, ready = 1, memory returns addr^32'hA5A5_0000 -> pc_o = 0,4,8,12 on consecutive cycles; first instr_valid_o 2 cycles after the first req.
2. ready = 0 for 10 cycles -> exactly DEPTH = 4 requests issued (0x0–0xC); imem_req_o stays 0; instr_valid_o held with pc_o = 0. Raise ready -> entries drain in order and fetching resumes at 0x10.
3. gnt toggling 1,0,1,0 with 3-cycle response latency -> no duplicate or skipped PCs; imem_addr_o is held stable while req && !gnt.
4. Redirect to 0x0000_0102 while 3 responses are outstanding -> next imem_addr_o = 0x100; the 3 stale responses are dropped; the first valid output has pc_o = 0x100 with the correct data.
5. redirect_i and imem_rvalid_i in the same cycle, with the FIFO full and ready = 1 -> nothing from the old path appears afterwards; instr_valid_o = 0 the next cycle.
6. rst asserted mid-stream for 1 cycle -> all outputs return to reset values; fetching restarts at RESET_PC.
